// File: rtl/sync_fifo.sv
// Single-clock FWFT stream FIFO: sync-read RAM, one prefetch stage (RAM read register)
// and a resettable output register, with occupancy flags and a sticky overflow flag.

module fifo_mem #(
    parameter int DataWidth = 8,
    parameter int Depth     = 16,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [AddrWidth-1:0] i_waddr,
    input  logic [DataWidth-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [AddrWidth-1:0] i_raddr,
    output logic [DataWidth-1:0] o_rdata
);
    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;

    // NOTE: storage has no reset; valid tracking outside the RAM keeps stale words hidden.
    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        // Write-first: reading the slot being written returns the new word.
        if (i_re) rdata_q <= (i_we && (i_waddr == i_raddr)) ? i_wdata : mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;
endmodule

module sync_fifo #(
    parameter int   DataWidth        = 8,
    parameter int   Depth            = 16,
    parameter int   AlmostFullLevel  = Depth - 2,
    parameter int   AlmostEmptyLevel = 2,
    localparam int  CountWidth       = $clog2(Depth + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [DataWidth-1:0]  i_wr_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DataWidth-1:0]  o_rd_data,
    output logic [CountWidth-1:0] o_count,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic                  o_overflow
);
    localparam int AddrWidth = $clog2(Depth);
    localparam int PtrWidth  = AddrWidth + 1;

    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  pre_valid_q, pre_valid_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DataWidth-1:0]  rd_data_q, rd_data_d;
    logic                  overflow_q, overflow_d;
    logic [DataWidth-1:0]  ram_rdata;

    logic full, traffic_en, wr_accept, pop, load_out, ram_rd;

    assign full       = (count_q == CountWidth'(Depth));
    assign traffic_en = !i_rst && !i_flush;
    assign wr_accept  = traffic_en && i_wr_valid && !full;
    assign pop        = traffic_en && rd_valid_q && i_rd_ready;
    assign load_out   = traffic_en && pre_valid_q && (!rd_valid_q || pop);
    // Refill the prefetch stage when it frees up and RAM holds (or is receiving) a word.
    assign ram_rd     = traffic_en && (!pre_valid_q || load_out)
                        && ((wr_ptr_q != rd_ptr_q) || wr_accept);

    fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (wr_accept),
        .i_waddr (wr_ptr_q[AddrWidth-1:0]),
        .i_wdata (i_wr_data),
        .i_re    (ram_rd),
        .i_raddr (rd_ptr_q[AddrWidth-1:0]),
        .o_rdata (ram_rdata)
    );

    // NOTE: every next-state signal gets a default first, so no latch can be inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pre_valid_d = pre_valid_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        overflow_d  = overflow_q;

        if (i_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pre_valid_d = 1'b0;
            rd_valid_d  = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (i_wr_valid && full) overflow_d = 1'b1;
            if (wr_accept) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (ram_rd) rd_ptr_d = rd_ptr_q + PtrWidth'(1);

            if (load_out) begin
                rd_valid_d = 1'b1;
                rd_data_d  = ram_rdata;
            end else if (pop) begin
                rd_valid_d = 1'b0;
            end

            if (ram_rd) pre_valid_d = 1'b1;
            else if (load_out) pre_valid_d = 1'b0;

            case ({wr_accept, pop})
                2'b10:   count_d = count_q + CountWidth'(1);
                2'b01:   count_d = count_q - CountWidth'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pre_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pre_valid_q <= pre_valid_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_wr_ready     = !full;
    assign o_rd_valid     = rd_valid_q;
    assign o_rd_data      = rd_data_q;
    assign o_count        = count_q;
    assign o_empty        = (count_q == '0);
    assign o_full         = full;
    assign o_almost_full  = (count_q >= CountWidth'(AlmostFullLevel));
    assign o_almost_empty = (count_q <= CountWidth'(AlmostEmptyLevel));
    assign o_overflow     = overflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (Depth=16, DataWidth=8, default almost levels).
// Inputs change and outputs are sampled on the falling edge.

module tb_sync_fifo;
    localparam int DataWidth  = 8;
    localparam int Depth      = 16;
    localparam int CountWidth = $clog2(Depth + 1);

    logic                  clk = 1'b0;
    logic                  rst, flush, wr_valid, rd_ready;
    logic [DataWidth-1:0]  wr_data;
    logic                  wr_ready, rd_valid, empty, full, almost_empty, almost_full, overflow;
    logic [DataWidth-1:0]  rd_data;
    logic [CountWidth-1:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo #(
        .DataWidth        (DataWidth),
        .Depth            (Depth),
        .AlmostFullLevel  (14),
        .AlmostEmptyLevel (2)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flush        (flush),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_data      (wr_data),
        .o_rd_valid     (rd_valid),
        .i_rd_ready     (rd_ready),
        .o_rd_data      (rd_data),
        .o_count        (count),
        .o_empty        (empty),
        .o_full         (full),
        .o_almost_empty (almost_empty),
        .o_almost_full  (almost_full),
        .o_overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, ".rd_valid"},     rd_valid,     0);
        check({pfx, ".rd_data"},      rd_data,      0);
        check({pfx, ".count"},        count,        0);
        check({pfx, ".empty"},        empty,        1);
        check({pfx, ".full"},         full,         0);
        check({pfx, ".wr_ready"},     wr_ready,     1);
        check({pfx, ".almost_empty"}, almost_empty, 1);
        check({pfx, ".almost_full"},  almost_full,  0);
        check({pfx, ".overflow"},     overflow,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        @(negedge clk);
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Single word: count after the accept edge, data one edge later.
        wr_valid = 1'b1; wr_data = 8'h5A;
        tick();
        wr_valid = 1'b0;
        check("first.count",    count,    1);
        check("first.empty",    empty,    0);
        check("first.rd_valid", rd_valid, 0);
        tick();
        check("first.rd_valid2", rd_valid, 1);
        check("first.rd_data",   rd_data,  8'h5A);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("first.pop_valid", rd_valid, 0);
        check("first.pop_count", count,    0);
        check("first.pop_empty", empty,    1);

        // Fill to full while walking the almost flags.
        for (int i = 0; i < Depth; i++) begin
            wr_valid = 1'b1; wr_data = DataWidth'(i);
            tick();
            check($sformatf("fill%0d.count", i), count, i + 1);
            check($sformatf("fill%0d.aempty", i), almost_empty, (i + 1) <= 2);
            check($sformatf("fill%0d.afull", i), almost_full, (i + 1) >= 14);
        end
        wr_valid = 1'b0;
        check("full.full",     full,     1);
        check("full.wr_ready", wr_ready, 0);
        check("full.rd_valid", rd_valid, 1);
        check("full.rd_data",  rd_data,  8'h00);

        wr_valid = 1'b1; wr_data = 8'hFF;
        tick();
        wr_valid = 1'b0;
        check("ovf.overflow", overflow, 1);
        check("ovf.count",    count,    16);

        // Push and pop together while full: push is refused.
        wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
        check("pushpop.head", rd_data, 8'h00);
        tick();
        wr_valid = 1'b0; rd_ready = 1'b0;
        check("pushpop.count",    count,    15);
        check("pushpop.full",     full,     0);
        check("pushpop.overflow", overflow, 1);
        tick();
        check("stall.rd_valid", rd_valid, 1);
        check("stall.rd_data",  rd_data,  8'h01);

        rd_ready = 1'b1;
        for (int i = 1; i < Depth; i++) begin
            check($sformatf("drain%0d.valid", i), rd_valid, 1);
            check($sformatf("drain%0d.data", i),  rd_data,  i);
            tick();
        end
        rd_ready = 1'b0;
        check("drain.rd_valid", rd_valid, 0);
        check("drain.count",    count,    0);
        check("drain.empty",    empty,    1);
        check("drain.overflow", overflow, 1);

        // Flush with 5 stored words and a write offered in the same cycle.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = DataWidth'(8'h30 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("preflush.count", count, 5);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
        tick();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        check("flush.count",    count,    0);
        check("flush.rd_valid", rd_valid, 0);
        check("flush.overflow", overflow, 0);
        check("flush.empty",    empty,    1);
        tick();
        check("flush.idle_valid", rd_valid, 0);
        wr_valid = 1'b1; wr_data = 8'hA5;
        tick();
        wr_valid = 1'b0;
        tick();
        check("postflush.valid", rd_valid, 1);
        check("postflush.data",  rd_data,  8'hA5);
        check("postflush.count", count,    1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("postflush.pop_valid", rd_valid, 0);
        check("postflush.pop_count", count,    0);

        // Streaming: 64 words, one in and one out per cycle after fill-up.
        rd_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            wr_valid = 1'b1; wr_data = DataWidth'(k);
            check($sformatf("stream%0d.count", k), count, (k < 2) ? k : 2);
            if (k >= 2) begin
                check($sformatf("stream%0d.valid", k), rd_valid, 1);
                check($sformatf("stream%0d.data", k),  rd_data,  k - 2);
            end
            tick();
        end
        wr_valid = 1'b0;
        check("stream.tail62", rd_data, 62);
        tick();
        check("stream.tail63", rd_data, 63);
        tick();
        rd_ready = 1'b0;
        check("stream.end_valid", rd_valid, 0);
        check("stream.end_count", count,    0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = DataWidth'(8'h40 + i);
            tick();
        end
        rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h11; rd_ready = 1'b1;
        tick();
        check_reset("midrst");
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        tick();
        check_reset("midrst_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous stream FIFO with valid/ready handshakes on both sides, first-word-fall-through output, occupancy count, programmable almost-full/almost-empty levels, synchronous flush and a sticky overflow flag. Builds on the `fifo_mem` dual-port RAM (sync read, sync write, no reset) plus a resettable output stage. It sits between the UART byte engines and the bus-side registers, and is the general buffering block for any single-clock stream.

## Interface
- DataWidth, 8, word width in bits (≥1).
- Depth, 16, total capacity in words; power of two, ≥4.
- AlmostFullLevel, Depth-2, o_almost_full asserts when count ≥ this value (1..Depth).
- AlmostEmptyLevel, 2, o_almost_empty asserts when count ≤ this value (0..Depth-1).
- CountWidth, $clog2(Depth+1), localparam.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are i_clk and i_rst, and all state updates on the posedge of i_clk.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_flush  in  1  synchronous clear of contents and flags.
- i_wr_valid  in  1  write word offered.
- o_wr_ready  out  1  FIFO can accept a word.
- i_wr_data  in  DataWidth  write word.
- o_rd_valid  out  1  o_rd_data holds the oldest word.
- i_rd_ready  in  1  consumer takes the word.
- o_rd_data  out  DataWidth  oldest word (FWFT).
- o_count  out  CountWidth  words accepted and not yet popped.
- o_empty, o_full, o_almost_empty, o_almost_full  out  1 each  occupancy flags.
- o_overflow  out  1  sticky: a write was offered while the FIFO was full.

## Operation
- A write is accepted on an edge where i_wr_valid && o_wr_ready. A pop happens on an edge where o_rd_valid && i_rd_ready.
- o_wr_ready = !o_full. It is registered-state derived and never depends on i_rd_ready in the same cycle. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
- o_count: +1 on accept only, −1 on pop only, unchanged when both occur or neither occurs. Range 0..Depth.
- o_full = (count == Depth). o_empty = (count == 0).
- o_almost_full = (count ≥ AlmostFullLevel). o_almost_empty = (count ≤ AlmostEmptyLevel).
- Storage: fifo_mem plus an output register. Write and read pointers are $clog2(Depth)+1 bits and wrap modulo 2·Depth, so wrap-around needs no special handling.
- The prefetch logic keeps the output register loaded whenever a word is in RAM and the register is empty or being popped. Order is strictly FIFO.
- o_overflow is set on any edge with i_wr_valid && o_full. The offered word is dropped. The flag clears only on i_rst or i_flush.
- i_flush: pointers, count, o_rd_valid and o_overflow clear on that edge. Any write or pop in the same cycle is ignored. i_rst has priority over i_flush, and i_flush has priority over all traffic.
- RAM contents are not cleared by reset or flush. Stale data must never become visible.

## Timing
- Reset values (after the edge with i_rst=1): o_rd_valid=0, o_rd_data=0, o_count=0, o_empty=1, o_full=0, o_wr_ready=1, o_almost_empty=1, o_almost_full=0 (with default levels), o_overflow=0.
- Reset mid-operation: all of the above values hold on the next cycle. In-flight words are discarded.
- Write-to-read latency into an empty FIFO: word accepted at edge N → o_rd_valid=1 with that word after edge N+2.
- o_count and o_empty update after edge N+1. o_empty therefore deasserts one cycle before o_rd_valid asserts.
- Sustained throughput: one accept and one pop per cycle, indefinitely, with no bubbles once o_rd_valid=1.
- o_rd_data and o_rd_valid stay stable while o_rd_valid && !i_rd_ready.
- The pop of the last word clears o_rd_valid after that edge, unless a refill is already in the pipeline.

## Test plan
- Reset → all outputs at their reset values. Push 0x5A at edge N → o_count=1 after N+1; o_rd_valid=1 with o_rd_data=0x5A after N+2.
- Depth=16: push 0x00..0x0F with i_rd_ready=0 → o_full=1, o_wr_ready=0, o_count=16. Offer 0xFF → o_overflow=1, 0xFF never appears. Drain → 0x00..0x0F in order, o_overflow still 1.
- Continuous push/pop of 64 incrementing words (4 pointer wraps) → output sequence identical to input, count stays constant, no bubbles.
- Almost flags with defaults: o_almost_empty=1 at counts 0..2 and 0 at count 3; o_almost_full=1 at counts 14..16 and 0 at count 13.
- With the FIFO full, push and pop in the same cycle → push refused, count goes 16→15, o_overflow=1.
- With 5 words stored, assert i_flush with i_wr_valid=1 → after the edge o_count=0, o_rd_valid=0, o_overflow=0. A following push of 0xA5 is the first word out, with no stale data.
